fbcpu_mem_boot: RTL and testbench
=================================

// Module: fbcpu_mem_boot
// PURPOSE
//  Memory-side responder for the FB-CPU bus (MAR/RAMWr/MDRIn -> MDROut): owns the program/data RAM.
//  Adds a streaming boot loader that fills RAM from a host while holding the CPU in reset.
//  Releases the CPU at PC=0 once loading completes. Sits between the host/testbench loader and FBCPU.
// PARAMETERS
//  ADDRESS_WIDTH  6   CPU word-address width; DEPTH = 2**ADDRESS_WIDTH words
//  DATA_WIDTH     10  word width (4-bit opcode + 6-bit operand)
// PORTS
//  clk         in   1       clock; all state updates on rising edge
//  rst         in   1       reset, synchronous, active-high
//  mar         in   AW      CPU address (FBCPU MAR)
//  ram_wr      in   1       CPU write strobe (FBCPU RAMWr)
//  mdr_in      in   DW      CPU write data (FBCPU MDRIn)
//  mdr_out     out  DW      registered read data to CPU (FBCPU MDROut)
//  cpu_rst     out  1       drives FBCPU rst; 1 whenever the CPU must not run
//  ld_start    in   1       pulse: begin (re)load at address 0
//  ld_valid    in   1       loader word valid
//  ld_data     in   DW      loader word
//  ld_last     in   1       qualifies final word of image (sampled with ld_valid)
//  ld_ready    out  1       loader may transfer this cycle
//  load_done   out  1       1-cycle pulse when load terminates (normal or error)
//  load_err    out  1       sticky: image longer than DEPTH
//  load_count  out  AW+1    words written in current/last load (0..DEPTH)
// BEHAVIOUR
//  Reset: state=IDLE, cpu_rst=1, ld_ready=0, load_done=0, load_err=0, load_count=0, mdr_out=0.
//   RAM contents are not cleared by rst; reset mid-load leaves partially written words in place.
//  FSM (registered): IDLE -> LOAD on ld_start. LOAD -> DONE on accepted beat with ld_last, or on overflow.
//   DONE -> RUN unconditionally after 1 cycle. RUN -> LOAD on ld_start (reload; CPU re-held).
//   ld_start is ignored in LOAD and DONE.
//  cpu_rst: registered, =1 in IDLE/LOAD/DONE, =0 in RUN. First RUN cycle: CPU state 0 fetches PC=0.
//  LOAD: ld_ready=1 (combinational from state). Beat = ld_valid & ld_ready.
//   Pointer clears to 0 on LOAD entry. Each beat writes mem[ptr]=ld_data; ptr++, load_count++.
//   ld_valid gaps allowed; no timeout.
//   Overflow: beat arrives with load_count==DEPTH -> word dropped, load_err=1, go DONE.
//   Exactly DEPTH words with ld_last on the final one is legal; no error.
//   load_err/load_count clear on LOAD entry; otherwise held until next load or rst.
//  load_done: 1 exactly in the DONE cycle.
//  CPU port active only in RUN:
//   Read: mdr_out <= mem[mar] every clock. Latency 1; matches FBCPU fetch (MAR in state 0, IR latch in state 1).
//   Write: ram_wr=1 writes mdr_in to mem[mar] at the edge.
//   Same-address read-during-write is read-first: mdr_out returns the old word, new word visible next cycle.
//   Outside RUN, ram_wr is ignored (no write) and mdr_out is held at 0.
//  Single RAM write port: loader and CPU writes are mutually exclusive by state, so no arbitration is needed.
//  Address arithmetic is modulo DEPTH; ptr never wraps because overflow terminates LOAD first.
// STRUCTURE
//  Shared package fbcpu_pkg: ADDRESS_WIDTH/DATA_WIDTH defaults; boot_state_t {IDLE,LOAD,DONE,RUN};
//   opcode constants (LDA=0,STA=1,ADD=2,SUB=3,MUL=4,DIV=5,JMP=6,JZ=7,NOP=8,HLT=9) for TB images.
//  Sub-module fbcpu_ram_1rw: DEPTH x DW array, one write port (we/waddr/wdata), registered read-first read port.
//  Top level holds the FSM, load pointer/counters, and write-source mux.
// TESTING
//  T1 rst, ld_start, 3 beats 0x005,0x0C7,0x200 (last on 3rd) -> mem[0..2] match, load_count=3,
//     load_done pulse 1 cycle, cpu_rst 1->0 on the next edge.
//  T2 RUN, mar=2 -> mdr_out=0x200 exactly 1 cycle later; mar change each cycle tracks with 1-cycle lag.
//  T3 RUN, mem[5]=0x011, ram_wr=1 mar=5 mdr_in=0x3FF -> same-cycle read returns 0x011; next read 0x3FF.
//  T4 Load 65 beats, no ld_last (DEPTH=64) -> beat 65 dropped, load_err=1, load_count=64, mem[63]=beat 64.
//  T5 ld_valid toggling 1,0,0,1,1 with ld_start pulses mid-LOAD -> only valid beats written, ld_start ignored.
//     Also ram_wr=1 during LOAD -> no CPU write occurs.
//  T6 rst after 2 of 4 beats -> IDLE, cpu_rst=1, load_count=0, mem[0..1] retain data.
//     Reload from RUN via ld_start -> cpu_rst reasserts the next cycle.

Source files
------------

// File: rtl/fbcpu_pkg.sv
// Shared FB-CPU definitions: bus width defaults, boot FSM states, opcodes for test images.
package fbcpu_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH = 6;
  localparam int unsigned DEF_DATA_WIDTH    = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    RUN  = 2'd3
  } boot_state_t;

  localparam logic [3:0] LDA = 4'd0;
  localparam logic [3:0] STA = 4'd1;
  localparam logic [3:0] ADD = 4'd2;
  localparam logic [3:0] SUB = 4'd3;
  localparam logic [3:0] MUL = 4'd4;
  localparam logic [3:0] DIV = 4'd5;
  localparam logic [3:0] JMP = 4'd6;
  localparam logic [3:0] JZ  = 4'd7;
  localparam logic [3:0] NOP = 4'd8;
  localparam logic [3:0] HLT = 4'd9;

endpackage

// File: rtl/fbcpu_ram_1rw.sv
// Program/data RAM: one write port, registered read-first read port that returns 0 when disabled.
module fbcpu_ram_1rw #(
  parameter int unsigned ADDRESS_WIDTH = 6,
  parameter int unsigned DATA_WIDTH    = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDRESS_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [ADDRESS_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array write; contents deliberately survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; old word is returned on a same-address write.
  always_ff @(posedge clk) begin
    if (rst || !re) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fbcpu_mem_boot.sv
// FB-CPU memory responder with a streaming boot loader that holds the CPU in reset while filling RAM.
module fbcpu_mem_boot
  import fbcpu_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] mar,
  input  logic                     ram_wr,
  input  logic [DATA_WIDTH-1:0]    mdr_in,
  output logic [DATA_WIDTH-1:0]    mdr_out,
  output logic                     cpu_rst,
  input  logic                     ld_start,
  input  logic                     ld_valid,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  input  logic                     ld_last,
  output logic                     ld_ready,
  output logic                     load_done,
  output logic                     load_err,
  output logic [ADDRESS_WIDTH:0]   load_count
);

  localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;
  localparam int unsigned CW    = ADDRESS_WIDTH + 1;

  boot_state_t              state;
  boot_state_t              state_d;
  logic                     beat;
  logic                     count_full;
  logic                     ram_we;
  logic [ADDRESS_WIDTH-1:0] ram_waddr;
  logic [DATA_WIDTH-1:0]    ram_wdata;
  logic                     ram_re;

  assign ld_ready   = (state == LOAD);
  assign beat       = ld_valid & ld_ready;
  assign count_full = (load_count == CW'(DEPTH));
  // CPU reads only while it keeps running; the cycle leaving RUN already returns 0.
  assign ram_re     = (state == RUN) && (state_d == RUN);

  // Next state and write-source selection (loader in LOAD, CPU in RUN).
  always_comb begin
    state_d   = state;
    ram_we    = 1'b0;
    ram_waddr = mar;
    ram_wdata = mdr_in;
    case (state)
      IDLE: begin
        if (ld_start) state_d = LOAD;
      end
      LOAD: begin
        if (beat) begin
          if (count_full) begin
            state_d = DONE;
          end else begin
            ram_we    = 1'b1;
            ram_waddr = load_count[ADDRESS_WIDTH-1:0];
            ram_wdata = ld_data;
            if (ld_last) state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = RUN;
      end
      RUN: begin
        ram_we = ram_wr;
        if (ld_start) state_d = LOAD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, CPU reset, done pulse and loader counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cpu_rst    <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
      load_count <= '0;
    end else begin
      state     <= state_d;
      cpu_rst   <= (state_d != RUN);
      load_done <= (state_d == DONE);
      if ((state != LOAD) && (state_d == LOAD)) begin
        load_count <= '0;
        load_err   <= 1'b0;
      end else if (beat) begin
        if (count_full) begin
          load_err <= 1'b1;
        end else begin
          load_count <= load_count + CW'(1);
        end
      end
    end
  end

  fbcpu_ram_1rw #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (ram_re),
    .raddr(mar),
    .rdata(mdr_out)
  );

endmodule

// File: tb/tb_fbcpu_mem_boot.sv
// Directed bench for fbcpu_mem_boot: boot load, CPU port timing, overflow, gaps and reset.
module tb_fbcpu_mem_boot;
  import fbcpu_pkg::*;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] mar;
  logic          ram_wr;
  logic [DW-1:0] mdr_in;
  logic [DW-1:0] mdr_out;
  logic          cpu_rst;
  logic          ld_start;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   load_count;

  int n_vec = 0;
  int n_err = 0;

  fbcpu_mem_boot #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .mar(mar), .ram_wr(ram_wr), .mdr_in(mdr_in), .mdr_out(mdr_out),
    .cpu_rst(cpu_rst), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .load_done(load_done), .load_err(load_err),
    .load_count(load_count)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] ovf_word(input int i);
    return DW'(i * 7 + 1);
  endfunction

  function automatic logic [DW-1:0] exact_word(input int i);
    return DW'(i + 100);
  endfunction

  task automatic test_reset();
    rst = 1'b1; mar = '0; ram_wr = 1'b0; mdr_in = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    tick(); tick();
    n_vec++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL reset.cpu_rst got %0h exp 1", cpu_rst); end
    n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL reset.ld_ready got %0h exp 0", ld_ready); end
    n_vec++; if (load_done !== 1'b0) begin n_err++; $display("FAIL reset.load_done got %0h exp 0", load_done); end
    n_vec++; if (load_err !== 1'b0) begin n_err++; $display("FAIL reset.load_err got %0h exp 0", load_err); end
    n_vec++; if (load_count !== 7'd0) begin n_err++; $display("FAIL reset.load_count got %0d exp 0", load_count); end
    n_vec++; if (mdr_out !== 10'h000) begin n_err++; $display("FAIL reset.mdr_out got %h exp 000", mdr_out); end
    rst = 1'b0;
    // ld_start absent: stays in IDLE with CPU held
    tick();
    n_vec++; if (cpu_rst !== 1'b1 || ld_ready !== 1'b0) begin n_err++; $display("FAIL idle.hold got cpu_rst=%0h ld_ready=%0h exp 1/0", cpu_rst, ld_ready); end
  endtask

  task automatic test_basic_load();
    logic [DW-1:0] img [3];
    img[0] = 10'h005; img[1] = 10'h0C7; img[2] = 10'h200;
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    n_vec++; if (ld_ready !== 1'b1) begin n_err++; $display("FAIL t1.ld_ready got %0h exp 1", ld_ready); end
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_data = img[i]; ld_last = (i == 2);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    n_vec++; if (load_done !== 1'b1) begin n_err++; $display("FAIL t1.load_done got %0h exp 1", load_done); end
    n_vec++; if (load_count !== 7'd3) begin n_err++; $display("FAIL t1.load_count got %0d exp 3", load_count); end
    n_vec++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL t1.cpu_rst_done got %0h exp 1", cpu_rst); end
    n_vec++; if (ld_ready !== 1'b0) begin n_err++; $display("FAIL t1.ld_ready_done got %0h exp 0", ld_ready); end
    tick();
    n_vec++; if (load_done !== 1'b0) begin n_err++; $display("FAIL t1.done_pulse got %0h exp 0", load_done); end
    n_vec++; if (cpu_rst !== 1'b0) begin n_err++; $display("FAIL t1.cpu_rst_run got %0h exp 0", cpu_rst); end
    n_vec++; if (mdr_out !== 10'h000) begin n_err++; $display("FAIL t1.mdr_first_run got %h exp 000", mdr_out); end
  endtask

  task automatic test_read_latency();
    logic [AW-1:0] seq [5];
    logic [DW-1:0] exp [5];
    seq[0] = 6'd2; seq[1] = 6'd0; seq[2] = 6'd1; seq[3] = 6'd2; seq[4] = 6'd0;
    exp[0] = 10'h200; exp[1] = 10'h005; exp[2] = 10'h0C7; exp[3] = 10'h200; exp[4] = 10'h005;
    for (int i = 0; i < 5; i++) begin
      mar = seq[i];
      tick();
      n_vec++; if (mdr_out !== exp[i]) begin n_err++; $display("FAIL t2.read[%0d] mar=%0d got %h exp %h", i, seq[i], mdr_out, exp[i]); end
    end
  endtask

  task automatic test_read_during_write();
    mar = 6'd5; ram_wr = 1'b1; mdr_in = 10'h011; tick();
    mdr_in = 10'h3FF; tick();
    n_vec++; if (mdr_out !== 10'h011) begin n_err++; $display("FAIL t3.read_first got %h exp 011", mdr_out); end
    ram_wr = 1'b0; tick();
    n_vec++; if (mdr_out !== 10'h3FF) begin n_err++; $display("FAIL t3.new_word got %h exp 3ff", mdr_out); end
  endtask

  task automatic test_overflow();
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    n_vec++; if (cpu_rst !== 1'b1) begin n_err++; $display("FAIL t4.reload_cpu_rst got %0h exp 1", cpu_rst); end
    n_vec++; if (load_count !== 7'd0) begin n_err++; $display("FAIL t4.count_clear got %0d exp 0", load_count); end
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1'b1; ld_data = ovf_word(i); ld_last = 1'b0;
      tick();
    end
    n_vec++; if (load_count !== 7'd64 || ld_ready !== 1'b1 || load_done !== 1'b0) begin
      n_err++; $display("FAIL t4.full got count=%0d ready=%0h done=%0h exp 64/1/0", load_count, ld_ready, load_done);
    end
    ld_data = 10'h155; tick();
    ld_valid = 1'b0;
    n_vec++; if (load_done !== 1'b1) begin n_err++; $display("FAIL t4.load_done got %0h exp 1", load_done); end
    n_vec++; if (load_err !== 1'b1) begin n_err++; $display("FAIL t4.load_err got %0h exp 1", load_err); end
    n_vec++; if (load_count !== 7'd64) begin n_err++; $display("FAIL t4.load_count got %0d exp 64", load_count); end
    tick();
    n_vec++; if (cpu_rst !== 1'b0 || load_err !== 1'b1) begin n_err++; $display("FAIL t4.run got cpu_rst=%0h err=%0h exp 0/1", cpu_rst, load_err); end
    mar = 6'd63; tick();
    n_vec++; if (mdr_out !== ovf_word(63)) begin n_err++; $display("FAIL t4.mem63 got %h exp %h", mdr_out, ovf_word(63)); end
    mar = 6'd0; tick();
    n_vec++; if (mdr_out !== ovf_word(0)) begin n_err++; $display("FAIL t4.mem0 got %h exp %h", mdr_out, ovf_word(0)); end
  endtask

  task automatic test_gaps();
    logic          v  [5];
    logic          st [5];
    logic          lst[5];
    logic [DW-1:0] d  [5];
    v[0] = 1; v[1] = 0; v[2] = 0; v[3] = 1; v[4] = 1;
    st[0] = 0; st[1] = 1; st[2] = 0; st[3] = 1; st[4] = 0;
    lst[0] = 0; lst[1] = 1; lst[2] = 0; lst[3] = 0; lst[4] = 1;
    d[0] = 10'h101; d[1] = 10'h102; d[2] = 10'h103; d[3] = 10'h104; d[4] = 10'h105;
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    n_vec++; if (load_err !== 1'b0) begin n_err++; $display("FAIL t5.err_clear got %0h exp 0", load_err); end
    mar = 6'd10; ram_wr = 1'b1; mdr_in = 10'h0AA;
    for (int i = 0; i < 5; i++) begin
      ld_valid = v[i]; ld_start = st[i]; ld_last = lst[i]; ld_data = d[i];
      tick();
      if (i == 2) begin
        n_vec++; if (load_count !== 7'd1 || ld_ready !== 1'b1) begin n_err++; $display("FAIL t5.gap got count=%0d ready=%0h exp 1/1", load_count, ld_ready); end
      end
    end
    ld_valid = 1'b0; ld_start = 1'b0; ld_last = 1'b0; ram_wr = 1'b0;
    n_vec++; if (load_done !== 1'b1 || load_count !== 7'd3 || load_err !== 1'b0) begin
      n_err++; $display("FAIL t5.done got done=%0h count=%0d err=%0h exp 1/3/0", load_done, load_count, load_err);
    end
    tick();
    mar = 6'd0; tick();
    n_vec++; if (mdr_out !== 10'h101) begin n_err++; $display("FAIL t5.mem0 got %h exp 101", mdr_out); end
    mar = 6'd1; tick();
    n_vec++; if (mdr_out !== 10'h104) begin n_err++; $display("FAIL t5.mem1 got %h exp 104", mdr_out); end
    mar = 6'd2; tick();
    n_vec++; if (mdr_out !== 10'h105) begin n_err++; $display("FAIL t5.mem2 got %h exp 105", mdr_out); end
    mar = 6'd3; tick();
    n_vec++; if (mdr_out !== ovf_word(3)) begin n_err++; $display("FAIL t5.mem3 got %h exp %h", mdr_out, ovf_word(3)); end
    mar = 6'd10; tick();
    n_vec++; if (mdr_out !== ovf_word(10)) begin n_err++; $display("FAIL t5.no_cpu_write got %h exp %h", mdr_out, ovf_word(10)); end
  endtask

  task automatic test_exact_depth();
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1'b1; ld_data = exact_word(i); ld_last = (i == 63);
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    n_vec++; if (load_done !== 1'b1 || load_err !== 1'b0 || load_count !== 7'd64) begin
      n_err++; $display("FAIL exact.done got done=%0h err=%0h count=%0d exp 1/0/64", load_done, load_err, load_count);
    end
    tick();
    mar = 6'd63; tick();
    n_vec++; if (mdr_out !== exact_word(63)) begin n_err++; $display("FAIL exact.mem63 got %h exp %h", mdr_out, exact_word(63)); end
  endtask

  task automatic test_reset_midload();
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 10'h3A1; tick();
    ld_data = 10'h3A2; tick();
    rst = 1'b1; ld_valid = 1'b0; tick();
    n_vec++; if (cpu_rst !== 1'b1 || ld_ready !== 1'b0) begin n_err++; $display("FAIL t6.rst got cpu_rst=%0h ready=%0h exp 1/0", cpu_rst, ld_ready); end
    n_vec++; if (load_count !== 7'd0 || mdr_out !== 10'h000) begin n_err++; $display("FAIL t6.rst got count=%0d mdr=%h exp 0/000", load_count, mdr_out); end
    rst = 1'b0; tick();
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    ld_valid = 1'b1; ld_data = 10'h0F0; ld_last = 1'b1; tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    n_vec++; if (load_count !== 7'd1 || load_done !== 1'b1) begin n_err++; $display("FAIL t6.reload got count=%0d done=%0h exp 1/1", load_count, load_done); end
    tick();
    mar = 6'd1; tick();
    n_vec++; if (mdr_out !== 10'h3A2) begin n_err++; $display("FAIL t6.mem1_kept got %h exp 3a2", mdr_out); end
    mar = 6'd0; tick();
    n_vec++; if (mdr_out !== 10'h0F0) begin n_err++; $display("FAIL t6.mem0 got %h exp 0f0", mdr_out); end
    mar = 6'd2; tick();
    n_vec++; if (mdr_out !== exact_word(2)) begin n_err++; $display("FAIL t6.mem2 got %h exp %h", mdr_out, exact_word(2)); end
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    n_vec++; if (cpu_rst !== 1'b1 || mdr_out !== 10'h000) begin n_err++; $display("FAIL t6.reassert got cpu_rst=%0h mdr=%h exp 1/000", cpu_rst, mdr_out); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_read_latency();
    test_read_during_write();
    test_overflow();
    test_gaps();
    test_exact_depth();
    test_reset_midload();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
